sound_glu_rw: RTL and testbench

SOUND_GLU_RW -- requirements
Module: sound_glu_rw

---
 rtl/sound_glu_rw.sv | 183 ++++++++++++++++++
 tb/tb_sound_glu_rw.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_glu_rw.sv
// Sound GLU register window at $C03C-$C03F: DOC / sound RAM access port
// and a two-stage volume + noise-gate audio path.
module sound_glu_rw #(
    parameter bit ENABLE = 1'b1,
    parameter int MEM_ADDR_W = 21,
    parameter logic [MEM_ADDR_W-1:0] RAM_BASE = 21'h0_4000,
    parameter int AUDIO_W = 16,
    parameter int GATE_THRESHOLD = 48
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      sel_i,
    input  logic [1:0]                addr_i,
    input  logic                      rw_n_i,
    input  logic [7:0]                data_i,
    output logic [7:0]                data_o,
    output logic                      mem_rd_o,
    output logic                      mem_wr_o,
    output logic [MEM_ADDR_W-1:0]     mem_addr_o,
    output logic [3:0]                mem_byte_en_o,
    output logic [31:0]               mem_data_o,
    input  logic                      mem_ready_i,
    input  logic [31:0]               mem_q_i,
    output logic                      doc_cs_o,
    output logic                      doc_we_o,
    output logic [7:0]                doc_addr_o,
    output logic [7:0]                doc_wdata_o,
    input  logic [7:0]                doc_rdata_i,
    input  logic signed [AUDIO_W-1:0] left_i,
    input  logic signed [AUDIO_W-1:0] right_i,
    input  logic                      audio_valid_i,
    output logic signed [AUDIO_W-1:0] audio_l_o,
    output logic signed [AUDIO_W-1:0] audio_r_o,
    output logic                      audio_valid_o
);

    localparam int PW   = AUDIO_W + 5;
    localparam int SMAX = (1 << (AUDIO_W - 1)) - 1;
    localparam int SMIN = -SMAX - 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

    state_t state_q, state_d;

    logic                  ram_sel_q, auto_inc_q;
    logic [3:0]            vol_q;
    logic [15:0]           ptr_q;
    logic [7:0]            buf_q;
    logic [1:0]            lane_q;
    logic [MEM_ADDR_W-1:0] addr_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic                  busy, acc, data_acc, ram_go, doc_go;

    logic                      s1_v;
    logic signed [AUDIO_W-1:0] s1_l, s1_r;

    assign busy     = (state_q != IDLE);
    assign acc      = ENABLE && sel_i && !reset_i;
    assign data_acc = acc && (addr_i == 2'd1);
    // RAM accesses arriving while a request is outstanding are dropped
    assign ram_go   = data_acc && ram_sel_q && !busy;
    assign doc_go   = data_acc && !ram_sel_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ram_go) state_d = rw_n_i ? RD : WR;
            WR, RD:  if (mem_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ram_sel_q  <= 1'b0;
            auto_inc_q <= 1'b0;
            vol_q      <= 4'hF;
            ptr_q      <= '0;
            buf_q      <= '0;
            lane_q     <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            if (acc && !rw_n_i) begin
                case (addr_i)
                    2'd0: begin
                        ram_sel_q  <= data_i[6];
                        auto_inc_q <= data_i[5];
                        vol_q      <= data_i[3:0];
                    end
                    2'd2:    ptr_q[7:0]  <= data_i;
                    2'd3:    ptr_q[15:8] <= data_i;
                    default: ;
                endcase
            end
            if (ram_go) begin
                addr_q <= RAM_BASE + MEM_ADDR_W'(ptr_q[15:2]);
                be_q   <= 4'b0001 << ptr_q[1:0];
                lane_q <= ptr_q[1:0];
                if (!rw_n_i) wdata_q <= {4{data_i}};
            end
            if ((ram_go || doc_go) && auto_inc_q) ptr_q <= ptr_q + 16'd1;
            if (state_q == RD && mem_ready_i)
                buf_q <= mem_q_i[{lane_q, 3'b000} +: 8];
        end
    end

    always_comb begin
        data_o = '0;
        case (addr_i)
            2'd0:    data_o = {busy, ram_sel_q, auto_inc_q, 1'b0, vol_q};
            2'd1:    data_o = (ram_sel_q || !ENABLE) ? buf_q : doc_rdata_i;
            2'd2:    data_o = ptr_q[7:0];
            2'd3:    data_o = ptr_q[15:8];
            default: data_o = '0;
        endcase
    end

    assign mem_wr_o      = (state_q == WR);
    assign mem_rd_o      = (state_q == RD);
    assign mem_addr_o    = addr_q;
    assign mem_byte_en_o = be_q;
    assign mem_data_o    = wdata_q;

    assign doc_cs_o    = doc_go;
    assign doc_we_o    = doc_go && !rw_n_i;
    assign doc_addr_o  = doc_go ? ptr_q[7:0] : 8'h00;
    assign doc_wdata_o = doc_go ? data_i : 8'h00;

    // volume 0..15 maps to a gain of (v+1)/16
    function automatic logic signed [AUDIO_W-1:0] scale(
        input logic signed [AUDIO_W-1:0] s,
        input logic [3:0]                v
    );
        logic signed [PW-1:0] p;
        p = PW'(s) * $signed(PW'({1'b0, v} + 5'd1));
        p = p >>> 4;
        if (p > PW'(SMAX))      scale = AUDIO_W'(SMAX);
        else if (p < PW'(SMIN)) scale = AUDIO_W'(SMIN);
        else                    scale = AUDIO_W'(p);
    endfunction

    function automatic logic signed [AUDIO_W-1:0] noise_gate(
        input logic signed [AUDIO_W-1:0] v
    );
        logic signed [AUDIO_W:0] w, mag;
        w   = (AUDIO_W+1)'(v);
        mag = (w < 0) ? -w : w;
        noise_gate = v;
        if (GATE_THRESHOLD != 0 && mag < (AUDIO_W+1)'(GATE_THRESHOLD))
            noise_gate = '0;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_v          <= 1'b0;
            s1_l          <= '0;
            s1_r          <= '0;
            audio_valid_o <= 1'b0;
            audio_l_o     <= '0;
            audio_r_o     <= '0;
        end else if (ENABLE) begin
            s1_v <= audio_valid_i;
            if (audio_valid_i) begin
                s1_l <= scale(left_i, vol_q);
                s1_r <= scale(right_i, vol_q);
            end
            audio_valid_o <= s1_v;
            if (s1_v) begin
                audio_l_o <= noise_gate(s1_l);
                audio_r_o <= noise_gate(s1_r);
            end
        end
    end

endmodule

// File: tb/tb_sound_glu_rw.sv
// Randomised bench for sound_glu_rw against a byte-level register/RAM
// model and an arithmetic audio model.
module tb_sound_glu_rw;

    localparam logic [20:0] BASE = 21'h0_4000;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic sel_i = 1'b0;
    logic [1:0] addr_i = 2'd0;
    logic rw_n_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic [7:0] data_o;
    logic mem_rd_o, mem_wr_o;
    logic [20:0] mem_addr_o;
    logic [3:0] mem_byte_en_o;
    logic [31:0] mem_data_o;
    logic mem_ready_i = 1'b0;
    logic [31:0] mem_q_i = 32'h0;
    logic doc_cs_o, doc_we_o;
    logic [7:0] doc_addr_o, doc_wdata_o;
    logic [7:0] doc_rdata_i = 8'h00;
    logic signed [15:0] left_i = 16'sd0, right_i = 16'sd0;
    logic audio_valid_i = 1'b0;
    logic signed [15:0] audio_l_o, audio_r_o;
    logic audio_valid_o;

    logic [7:0] off_data_o;
    logic off_mem_rd_o, off_mem_wr_o;
    logic [20:0] off_mem_addr_o;
    logic [3:0] off_mem_byte_en_o;
    logic [31:0] off_mem_data_o;
    logic off_doc_cs_o, off_doc_we_o;
    logic [7:0] off_doc_addr_o, off_doc_wdata_o;
    logic signed [15:0] off_audio_l_o, off_audio_r_o;
    logic off_audio_valid_o;

    always #5 clk = ~clk;

    sound_glu_rw u_dut (
        .clk_i(clk), .reset_i(reset_i), .sel_i(sel_i), .addr_i(addr_i),
        .rw_n_i(rw_n_i), .data_i(data_i), .data_o(data_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_byte_en_o(mem_byte_en_o), .mem_data_o(mem_data_o),
        .mem_ready_i(mem_ready_i), .mem_q_i(mem_q_i),
        .doc_cs_o(doc_cs_o), .doc_we_o(doc_we_o), .doc_addr_o(doc_addr_o),
        .doc_wdata_o(doc_wdata_o), .doc_rdata_i(doc_rdata_i),
        .left_i(left_i), .right_i(right_i), .audio_valid_i(audio_valid_i),
        .audio_l_o(audio_l_o), .audio_r_o(audio_r_o),
        .audio_valid_o(audio_valid_o)
    );

    sound_glu_rw #(.ENABLE(1'b0)) u_off (
        .clk_i(clk), .reset_i(reset_i), .sel_i(sel_i), .addr_i(addr_i),
        .rw_n_i(rw_n_i), .data_i(data_i), .data_o(off_data_o),
        .mem_rd_o(off_mem_rd_o), .mem_wr_o(off_mem_wr_o),
        .mem_addr_o(off_mem_addr_o), .mem_byte_en_o(off_mem_byte_en_o),
        .mem_data_o(off_mem_data_o), .mem_ready_i(mem_ready_i),
        .mem_q_i(mem_q_i), .doc_cs_o(off_doc_cs_o), .doc_we_o(off_doc_we_o),
        .doc_addr_o(off_doc_addr_o), .doc_wdata_o(off_doc_wdata_o),
        .doc_rdata_i(doc_rdata_i), .left_i(left_i), .right_i(right_i),
        .audio_valid_i(audio_valid_i), .audio_l_o(off_audio_l_o),
        .audio_r_o(off_audio_r_o), .audio_valid_o(off_audio_valid_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // environment memory and its responder
    logic [31:0] mem_env [logic [20:0]];
    logic [31:0] shadow  [logic [20:0]];
    logic auto_mem = 1'b1;
    int delay = 1;
    int wait_cnt = 0;
    int wr_cycles = 0;
    int req_done = 0;
    logic unstable = 1'b0;
    logic [20:0] cap_addr;
    logic [3:0] cap_be;
    logic [31:0] cap_data, env_w;
    int off_act = 0;

    function automatic logic [31:0] mem_default(input logic [20:0] a);
        return {a[7:0], ~a[7:0], a[15:8], 8'h3C};
    endfunction

    function automatic logic [31:0] env_rd(input logic [20:0] a);
        return mem_env.exists(a) ? mem_env[a] : mem_default(a);
    endfunction

    function automatic logic [31:0] sh_rd(input logic [20:0] a);
        return shadow.exists(a) ? shadow[a] : mem_default(a);
    endfunction

    initial forever begin
        @(negedge clk);
        if (mem_wr_o) wr_cycles++;
        if (auto_mem) begin
            if (mem_wr_o || mem_rd_o) begin
                if (wait_cnt == 0) begin
                    cap_addr = mem_addr_o;
                    cap_be   = mem_byte_en_o;
                    cap_data = mem_data_o;
                end else if (mem_addr_o !== cap_addr ||
                             mem_byte_en_o !== cap_be ||
                             mem_data_o !== cap_data) begin
                    unstable = 1'b1;
                end
                if (wait_cnt == delay) begin
                    mem_ready_i = 1'b1;
                    wait_cnt = 0;
                    req_done++;
                    if (mem_wr_o) begin
                        env_w = env_rd(mem_addr_o);
                        for (int b = 0; b < 4; b++)
                            if (mem_byte_en_o[b])
                                env_w[8*b +: 8] = mem_data_o[8*b +: 8];
                        mem_env[mem_addr_o] = env_w;
                    end else begin
                        mem_q_i = env_rd(mem_addr_o);
                    end
                end else begin
                    mem_ready_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ready_i = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk)
        if (off_mem_wr_o || off_mem_rd_o || off_doc_cs_o ||
            off_audio_valid_o || off_audio_l_o != 0 || off_audio_r_o != 0)
            off_act++;

    logic doc_cs_s, doc_we_s;
    logic [7:0] doc_addr_s, doc_wdata_s, off_q;

    task automatic bus_op(input logic [1:0] a, input logic rw,
                          input logic [7:0] d, output logic [7:0] q);
        @(negedge clk);
        sel_i = 1'b1; rw_n_i = rw; addr_i = a; data_i = d;
        #1;
        q = data_o;
        doc_cs_s = doc_cs_o; doc_we_s = doc_we_o;
        doc_addr_s = doc_addr_o; doc_wdata_s = doc_wdata_o;
        off_q = off_data_o;
        @(negedge clk);
        sel_i = 1'b0; rw_n_i = 1'b1; data_i = 8'h00;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus_op(a, 1'b0, d, q);
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] q);
        bus_op(a, 1'b1, 8'h00, q);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((mem_wr_o || mem_rd_o) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(n < 60), 32'd1);
    endtask

    function automatic int exp_audio(input int s, input int vol);
        int p;
        p = (s * (vol + 1)) >>> 4;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        if (p < 48 && p > -48) p = 0;
        return p;
    endfunction

    task automatic send_sample(input int l, input int r, input int vol,
                               input string tag);
        @(negedge clk);
        left_i = 16'(l); right_i = 16'(r); audio_valid_i = 1'b1;
        @(negedge clk);
        audio_valid_i = 1'b0;
        @(negedge clk);
        check({tag, "_v"}, 32'(audio_valid_o), 32'd1);
        check({tag, "_l"}, 32'(audio_l_o), 32'(exp_audio(l, vol)));
        check({tag, "_r"}, 32'(audio_r_o), 32'(exp_audio(r, vol)));
        @(negedge clk);
        check({tag, "_vend"}, 32'(audio_valid_o), 32'd0);
    endtask

    logic [7:0] q, d, m_ctrl, m_buf;
    logic [15:0] m_ptr;
    logic [1:0] a;
    logic rw;
    logic [31:0] word;
    int snap, vol, l, r;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wr", 32'(mem_wr_o), 32'd0);
        check("rst_addr", 32'(mem_addr_o), 32'd0);
        check("rst_be", 32'(mem_byte_en_o), 32'd0);
        check("rst_aud_v", 32'(audio_valid_o), 32'd0);
        reset_i = 1'b0;
        bus_rd(2'd0, q); check("rst_ctrl", 32'(q), 32'h0F);
        check("off_ctrl", 32'(off_q), 32'h0F);
        bus_rd(2'd2, q); check("rst_plo", 32'(q), 32'h00);
        bus_rd(2'd3, q); check("rst_phi", 32'(q), 32'h00);
        check("rst_aud_l", 32'(audio_l_o), 32'd0);
        check("rst_doc", 32'(doc_cs_o), 32'd0);

        // RAM write with ready after three wait cycles
        bus_wr(2'd0, 8'h60); bus_wr(2'd2, 8'hFF); bus_wr(2'd3, 8'h12);
        delay = 3; wr_cycles = 0; unstable = 1'b0;
        bus_wr(2'd1, 8'hA5);
        wait_idle("w");
        check("w_cycles", 32'(wr_cycles), 32'd4);
        check("w_addr", 32'(cap_addr), 32'(BASE + 21'h4BF));
        check("w_be", 32'(cap_be), 32'h8);
        check("w_data", cap_data, 32'hA5A5A5A5);
        check("w_stable", 32'(unstable), 32'd0);
        bus_rd(2'd2, q); check("w_plo", 32'(q), 32'h00);
        bus_rd(2'd3, q); check("w_phi", 32'(q), 32'h13);
        bus_rd(2'd0, q); check("off_ctrl2", 32'(off_q), 32'h0F);

        // two RAM reads: the first returns the old buffer
        mem_env[BASE] = 32'h44332211;
        bus_wr(2'd2, 8'h01); bus_wr(2'd3, 8'h00);
        delay = 1;
        bus_rd(2'd1, q); check("r1_data", 32'(q), 32'h00);
        wait_idle("r1");
        bus_rd(2'd1, q); check("r2_data", 32'(q), 32'h22);
        wait_idle("r2");
        bus_rd(2'd2, q); check("r_plo", 32'(q), 32'h03);

        // RAM write attempted while busy
        bus_wr(2'd2, 8'h10);
        delay = 10; unstable = 1'b0; snap = req_done;
        bus_wr(2'd1, 8'h11);
        bus_wr(2'd1, 8'h22);
        bus_rd(2'd0, q); check("b_ctrl", 32'(q), 32'hE0);
        bus_rd(2'd2, q); check("b_plo", 32'(q), 32'h11);
        bus_wr(2'd2, 8'h40);
        wait_idle("b");
        check("b_reqs", 32'(req_done - snap), 32'd1);
        check("b_stable", 32'(unstable), 32'd0);
        check("b_mem", 32'(env_rd(BASE + 21'd4) & 32'hFF), 32'h11);
        bus_rd(2'd0, q); check("b_ctrl_idle", 32'(q), 32'h60);
        bus_rd(2'd2, q); check("b_plo2", 32'(q), 32'h40);

        // DOC access with pointer wrap
        bus_wr(2'd0, 8'h20); bus_wr(2'd2, 8'hFF); bus_wr(2'd3, 8'hFF);
        bus_op(2'd1, 1'b0, 8'h7F, q);
        check("d_cs", 32'(doc_cs_s), 32'd1);
        check("d_we", 32'(doc_we_s), 32'd1);
        check("d_addr", 32'(doc_addr_s), 32'hFF);
        check("d_wdata", 32'(doc_wdata_s), 32'h7F);
        #1 check("d_cs_end", 32'(doc_cs_o), 32'd0);
        bus_rd(2'd2, q); check("d_plo", 32'(q), 32'h00);
        bus_rd(2'd3, q); check("d_phi", 32'(q), 32'h00);
        doc_rdata_i = 8'h5C;
        bus_rd(2'd1, q);
        check("d_rdata", 32'(q), 32'h5C);
        check("d_rwe", 32'(doc_we_s), 32'd0);
        check("d_raddr", 32'(doc_addr_s), 32'h00);

        // audio corner cases
        bus_wr(2'd0, 8'h07);
        send_sample(1000, -1000, 7, "a_v7");
        send_sample(80, -80, 7, "a_gate");
        bus_wr(2'd0, 8'h0F);
        send_sample(-32768, 32767, 15, "a_unity");
        send_sample(48, 47, 15, "a_thr");
        bus_wr(2'd0, 8'h00);
        send_sample(1000, -1000, 0, "a_v0");
        bus_wr(2'd0, 8'h0F);
        fork
            send_sample(1000, 200, 15, "a_inflight");
            bus_wr(2'd0, 8'h03);
        join
        send_sample(1000, 200, 3, "a_newvol");
        bus_wr(2'd0, 8'h23);
        fork
            send_sample(-2000, 300, 3, "a_simul");
            bus_op(2'd1, 1'b0, 8'h3A, q);
        join
        check("simul_cs", 32'(doc_cs_s), 32'd1);
        check("simul_wdata", 32'(doc_wdata_s), 32'h3A);

        // reset while a RAM read is waiting
        bus_wr(2'd0, 8'h60);
        auto_mem = 1'b0;
        bus_rd(2'd1, q);
        check("x_rd", 32'(mem_rd_o), 32'd1);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("x_rd_drop", 32'(mem_rd_o), 32'd0);
        mem_q_i = 32'hFFFFFFFF; mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0;
        bus_rd(2'd0, q); check("x_ctrl", 32'(q), 32'h0F);
        bus_wr(2'd0, 8'h60);
        auto_mem = 1'b1; delay = 0;
        bus_rd(2'd1, q); check("x_buf", 32'(q), 32'h00);
        wait_idle("x");

        // random bus traffic against the model
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        m_ctrl = 8'h0F; m_ptr = 16'h0; m_buf = 8'h00;
        shadow = mem_env;
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 5))
                0: begin
                    d = 8'($urandom);
                    bus_wr(2'd0, d);
                    m_ctrl = d & 8'h6F;
                end
                1: begin
                    d = 8'($urandom);
                    bus_wr(2'd2, d);
                    m_ptr[7:0] = d;
                end
                2: begin
                    d = 8'($urandom_range(0, 1));
                    bus_wr(2'd3, d);
                    m_ptr[15:8] = d;
                end
                3: begin
                    vol = $urandom_range(0, 2);
                    a = (vol == 0) ? 2'd0 : (vol == 1) ? 2'd2 : 2'd3;
                    bus_rd(a, q);
                    check("rnd_reg", 32'(q),
                          32'((a == 2'd0) ? m_ctrl :
                              (a == 2'd2) ? m_ptr[7:0] : m_ptr[15:8]));
                end
                default: begin
                    rw = 1'($urandom);
                    d = 8'($urandom);
                    doc_rdata_i = 8'($urandom);
                    delay = $urandom_range(0, 4);
                    bus_op(2'd1, rw, d, q);
                    word = sh_rd(BASE + 21'(m_ptr >> 2));
                    check("rnd_cs", 32'(doc_cs_s), 32'(!m_ctrl[6]));
                    if (m_ctrl[6]) begin
                        if (rw) begin
                            check("rnd_buf", 32'(q), 32'(m_buf));
                            m_buf = word[8*m_ptr[1:0] +: 8];
                        end else begin
                            word[8*m_ptr[1:0] +: 8] = d;
                            shadow[BASE + 21'(m_ptr >> 2)] = word;
                        end
                        wait_idle("rnd");
                    end else begin
                        check("rnd_daddr", 32'(doc_addr_s), 32'(m_ptr[7:0]));
                        check("rnd_dwe", 32'(doc_we_s), 32'(!rw));
                        if (rw) check("rnd_drd", 32'(q), 32'(doc_rdata_i));
                        else check("rnd_dwd", 32'(doc_wdata_s), 32'(d));
                    end
                    if (m_ctrl[5]) m_ptr = m_ptr + 16'd1;
                end
            endcase
        end

        // random audio
        for (int i = 0; i < 30; i++) begin
            vol = $urandom_range(0, 15);
            d = {1'b0, m_ctrl[6:5], 1'b0, 4'(vol)};
            bus_wr(2'd0, d);
            m_ctrl = d;
            if ($urandom_range(0, 1) == 1) begin
                l = $urandom_range(0, 200) - 100;
                r = $urandom_range(0, 200) - 100;
            end else begin
                l = int'($signed(16'($urandom)));
                r = int'($signed(16'($urandom)));
            end
            send_sample(l, r, vol, "rnd_aud");
        end

        check("off_quiet", 32'(off_act), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
